rpm_monitor_multi: RTL and testbench
====================================

// Module: rpm_monitor_multi
// PURPOSE
//  Multi-channel tachometer. Counts rising edges of NCH Hall-sensor pulse inputs over a common
//  gate window of GATE_CYCLES clocks, latches all per-channel counts together, and raises a
//  per-channel overspeed alarm. Sits between the board pulse pins and the display/buzzer logic.
// PARAMETERS
//  NCH          4            number of pulse channels (1..8)
//  CNT_W        8            per-channel count width, bits
//  GATE_CYCLES  100_000_000  gate window length in clk cycles (>=4); default gives 1 s at 100 MHz
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous reset, active-high
//  en         in   1          run enable; 0 = idle/abort
//  pulse_in   in   NCH        raw asynchronous sensor pulses
//  thr_hi     in   CNT_W      alarm set threshold (shared by all channels)
//  thr_lo     in   CNT_W      alarm clear threshold (used only with RPM_HYST_EN)
//  count_out  out  NCH*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W]
//  count_vld  out  1          one-cycle strobe when count_out updates
//  alarm      out  NCH        per-channel overspeed flag
//  ovf        out  NCH        per-channel saturation flag for the last window
//  gate_act   out  1          high while a window is counting
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; gate timer and channel counters 0.
//  - Input path: 2-FF synchroniser, then rising-edge detect. An edge reaches the counter 3 clk
//    after the pin rises. Pulses shorter than 1 clk may be missed.
//  - FSM states:
//    - IDLE:  entered from reset or when en=0. -> GATE when en=1; the timer and counters clear.
//    - GATE:  gate_act=1. The timer increments each clk and each edge increments its channel
//             counter. -> LATCH when timer == GATE_CYCLES-1.
//    - LATCH: one cycle. count_out <= counters, ovf updated, alarm updated, count_vld=1.
//             Timer reloads to 0 and counters reload to 0. An edge in this cycle loads 1, so
//             edges are never lost across windows. -> GATE if en=1, otherwise IDLE.
//  - en=0 in GATE: abort to IDLE on the next clk. No latch, no count_vld.
//    count_out, alarm and ovf keep their last values.
//  - Counters saturate at 2^CNT_W-1 and do not wrap. ovf[i]=1 for that window if any edge
//    arrived while channel i was saturated.
//  - Alarm, without RPM_HYST_EN: at LATCH, alarm[i] <= (count_i > thr_hi). thr_lo is ignored.
//  - Comparisons are unsigned and CNT_W wide. thr_hi/thr_lo are sampled only in the LATCH cycle.
//  - Reset mid-window discards the window immediately; outputs return to reset values.
// CONFIGURATION
//  - RPM_HYST_EN defined: at LATCH, alarm[i] sets if count_i > thr_hi and clears if
//    count_i < thr_lo; otherwise it holds. If thr_lo > thr_hi, set has priority.
//  - RPM_HYST_EN undefined: single-threshold compare as in BEHAVIOUR; no hysteresis state.
// STRUCTURE
//  - Package rpm_pkg: FSM state encoding (IDLE, GATE, LATCH), default CNT_W, and the
//    SYNC_STAGES=2 constant.
//  - Sub-module rpm_edge_sync: synchroniser plus rising-edge detector, one instance per channel.
//    Gate timer, FSM, counters and alarm logic stay in the top.
// TESTING (GATE_CYCLES=20, NCH=2, CNT_W=4, thr_hi=5, thr_lo=2)
//  1. 7 pulses on ch0, 3 on ch1 within one window -> count_vld once; count_out ch0=7, ch1=3;
//     alarm=2'b01; ovf=0.
//  2. 18 pulses on ch0 in one window -> ch0 count=15, ovf[0]=1; next window with 4 pulses ->
//     count=4, ovf[0]=0.
//  3. Edge timed to land in the LATCH cycle -> excluded from the current count and counted as 1
//     in the next window.
//  4. en dropped at timer=10 -> no count_vld; outputs hold; en=1 restarts a full 20-cycle window.
//  5. RPM_HYST_EN: window counts 7,4,1 on ch0 -> alarm 1,1,0; without the macro -> 1,0,0.
//  6. rst pulsed mid-window -> all outputs 0 asynchronously; first count_vld 20+1 cycles after
//     en with rst low.

Source files
------------

// File: rtl/rpm_pkg.sv
// Shared definitions for the multi-channel tachometer: FSM encoding, default
// counter width and synchroniser depth.
package rpm_pkg;

   localparam int CNT_W_DEFAULT = 8;
   localparam int SYNC_STAGES   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GATE  = 2'd1,
      ST_LATCH = 2'd2
   } rpm_state_e;

endpackage

// File: rtl/rpm_edge_sync.sv
// Brings one asynchronous sensor pin into the clk domain and emits a one-clock
// pulse per rising edge, three clocks after the pin rises.
module rpm_edge_sync
   import rpm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Registered detector output keeps the counter enable glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q <= sync_out;
         rise_q <= sync_out & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/rpm_monitor_multi.sv
// Multi-channel tachometer: counts edges per channel over a common gate window
// and latches counts, saturation flags and overspeed alarms together.
// Optional macro RPM_HYST_EN adds set/clear hysteresis to the alarm.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not counting; outputs hold; waits for en
// ST_GATE  | window open; timer and channel counters advance
// ST_LATCH | one cycle; publish counts/ovf/alarm, reload for next window
module rpm_monitor_multi
   import rpm_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int GATE_CYCLES = 100_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NCH-1:0]       pulse_in,
   input  logic [CNT_W-1:0]     thr_hi,
   input  logic [CNT_W-1:0]     thr_lo,
   output logic [NCH*CNT_W-1:0] count_out,
   output logic                 count_vld,
   output logic [NCH-1:0]       alarm,
   output logic [NCH-1:0]       ovf,
   output logic                 gate_act
);

   localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   rpm_state_e                  state_q, state_d;
   logic [TMR_W-1:0]            tmr_q, tmr_d;
   logic [NCH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [NCH-1:0]              sat_q, sat_d;
   logic [NCH-1:0][CNT_W-1:0]   cnt_out_q, cnt_out_d;
   logic [NCH-1:0]              ovf_q, ovf_d;
   logic [NCH-1:0]              alarm_q, alarm_d;
   logic                        vld_q, vld_d;
   logic [NCH-1:0]              rise;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      rpm_edge_sync u_sync (
         .clk    (clk),
         .rst    (rst),
         .pin_i  (pulse_in[g]),
         .rise_o (rise[g])
      );
   end

`ifndef RPM_HYST_EN
   logic unused_thr_lo;
   assign unused_thr_lo = ^thr_lo;
`endif

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      cnt_out_d = cnt_out_q;
      ovf_d     = ovf_q;
      alarm_d   = alarm_q;
      vld_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_GATE;
               tmr_d   = '0;
               cnt_d   = '0;
               sat_d   = '0;
            end
         end

         ST_GATE: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
               for (int i = 0; i < NCH; i++) begin
                  if (rise[i]) begin
                     if (cnt_q[i] == CNT_MAX) begin
                        sat_d[i] = 1'b1;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                     end
                  end
               end
               if (tmr_q == TMR_LAST) begin
                  state_d = ST_LATCH;
               end
            end
         end

         ST_LATCH: begin
            vld_d     = 1'b1;
            cnt_out_d = cnt_q;
            ovf_d     = sat_q;
            tmr_d     = '0;
            sat_d     = '0;
            for (int i = 0; i < NCH; i++) begin
               // An edge arriving now opens the next window's count.
               cnt_d[i] = rise[i] ? CNT_W'(1) : '0;
`ifdef RPM_HYST_EN
               if (cnt_q[i] > thr_hi) begin
                  alarm_d[i] = 1'b1;
               end else if (cnt_q[i] < thr_lo) begin
                  alarm_d[i] = 1'b0;
               end
`else
               alarm_d[i] = (cnt_q[i] > thr_hi);
`endif
            end
            state_d = en ? ST_GATE : ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= '0;
         cnt_out_q <= '0;
         ovf_q     <= '0;
         alarm_q   <= '0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         cnt_out_q <= cnt_out_d;
         ovf_q     <= ovf_d;
         alarm_q   <= alarm_d;
         vld_q     <= vld_d;
      end
   end

   assign count_out = cnt_out_q;
   assign count_vld = vld_q;
   assign alarm     = alarm_q;
   assign ovf       = ovf_q;
   assign gate_act  = (state_q == ST_GATE);

endmodule

// File: tb/tb_rpm_monitor_multi.sv
// Scoreboard bench for rpm_monitor_multi (NCH=2, CNT_W=4, thr_hi=5, thr_lo=2).
// The gate is 40 cycles: a 20-cycle gate cannot hold the 18 edges needed to
// saturate a 4-bit counter through the synchroniser. One window = 41 clocks.
module tb_rpm_monitor_multi;

   localparam int NCH   = 2;
   localparam int CNT_W = 4;
   localparam int GATE  = 40;
   localparam int WIN   = GATE + 1;
`ifdef RPM_HYST_EN
   localparam bit HY = 1'b1;
`else
   localparam bit HY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic [NCH-1:0]   pulse_in = '0;
   logic [CNT_W-1:0] thr_hi = 4'd5;
   logic [CNT_W-1:0] thr_lo = 4'd2;
   logic [NCH*CNT_W-1:0] count_out;
   logic             count_vld;
   logic [NCH-1:0]   alarm;
   logic [NCH-1:0]   ovf;
   logic             gate_act;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] cnt;
      logic [1:0] alarm;
      logic [1:0] ovf;
   } exp_t;
   exp_t exp_q[$];

   rpm_monitor_multi #(.NCH(NCH), .CNT_W(CNT_W), .GATE_CYCLES(GATE)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .pulse_in  (pulse_in),
      .thr_hi    (thr_hi),
      .thr_lo    (thr_lo),
      .count_out (count_out),
      .count_vld (count_vld),
      .alarm     (alarm),
      .ovf       (ovf),
      .gate_act  (gate_act)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [3:0] c0, input logic [3:0] c1,
                           input logic [1:0] al, input logic [1:0] ov);
      exp_t e;
      e.cnt   = {c1, c0};
      e.alarm = al;
      e.ovf   = ov;
      exp_q.push_back(e);
   endtask

   // Starts at a negedge aligned to a window start; consumes exactly one window.
   task automatic run_window(input int n0, input int n1, input bit late0);
      for (int k = 0; k < WIN; k++) begin
         pulse_in[0] = ((k % 2 == 0) && (k / 2 < n0)) || (late0 && k == 38);
         pulse_in[1] = (k % 2 == 0) && (k / 2 < n1);
         @(negedge clk);
      end
   endtask

   task automatic measure_latency(input string name);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      @(posedge clk);
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (count_vld === 1'b1) seen = 1'b1;
      end
      check(name, n, GATE + 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_count_out"}, count_out, 8'h00);
      check({tag, "_count_vld"}, count_vld, 1'b0);
      check({tag, "_alarm"}, alarm, 2'b00);
      check({tag, "_ovf"}, ovf, 2'b00);
      check({tag, "_gate_act"}, gate_act, 1'b0);
   endtask

   exp_t got;
   initial begin
      forever begin
         @(negedge clk);
         if (count_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("vld_unexpected", count_vld, 1'b0);
            end else begin
               got = exp_q.pop_front();
               check("sb_count_out", count_out, got.cnt);
               check("sb_alarm", alarm, got.alarm);
               check("sb_ovf", ovf, got.ovf);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      en = 1'b1;

      push_exp(4'd7,  4'd3, 2'b01, 2'b00);              run_window(7, 3, 1'b0);
      push_exp(4'd15, 4'd0, 2'b01, 2'b01);              run_window(18, 0, 1'b0);
      push_exp(4'd4,  4'd0, HY ? 2'b01 : 2'b00, 2'b00); run_window(4, 0, 1'b0);
      push_exp(4'd1,  4'd0, 2'b00, 2'b00);              run_window(1, 0, 1'b0);
      push_exp(4'd7,  4'd0, 2'b01, 2'b00);              run_window(7, 0, 1'b0);
      push_exp(4'd4,  4'd0, HY ? 2'b01 : 2'b00, 2'b00); run_window(4, 0, 1'b0);
      push_exp(4'd1,  4'd0, 2'b00, 2'b00);              run_window(1, 0, 1'b0);
      push_exp(4'd0,  4'd2, 2'b00, 2'b00);              run_window(0, 2, 1'b1);
      push_exp(4'd1,  4'd0, 2'b00, 2'b00);              run_window(0, 0, 1'b0);
      push_exp(4'd5,  4'd6, 2'b10, 2'b00);              run_window(5, 6, 1'b0);

      // Abort: a few edges, then en drops as the timer reaches 10.
      for (int k = 0; k < 6; k++) begin
         pulse_in[0] = (k % 2 == 0);
         @(negedge clk);
      end
      pulse_in = '0;
      repeat (5) @(negedge clk);
      check("gate_act_before_abort", gate_act, 1'b1);
      en = 1'b0;
      @(negedge clk);
      check("gate_act_after_abort", gate_act, 1'b0);
      repeat (60) @(negedge clk);
      check("abort_hold_count", count_out, 8'h65);
      check("abort_hold_alarm", alarm, 2'b10);
      check("abort_hold_ovf", ovf, 2'b00);

      en = 1'b1;
      push_exp(4'd0, 4'd0, 2'b00, 2'b00);
      measure_latency("abort_restart_latency");
      @(negedge clk);
      push_exp(4'd7, 4'd1, 2'b01, 2'b00);
      run_window(7, 1, 1'b0);

      // Asynchronous reset in the middle of a running window.
      repeat (10) @(negedge clk);
      check("pre_rst_gate_act", gate_act, 1'b1);
      check("pre_rst_count", count_out, 8'h17);
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      push_exp(4'd0, 4'd0, 2'b00, 2'b00);
      measure_latency("reset_restart_latency");

      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
